// File: rtl/path_delay_meter_pkg.sv
// Shared constants and FSM encoding for the path delay meter.
package path_meter_pkg;

    localparam int DEF_CNT_W         = 16;
    localparam int DEF_SETTLE_CYCLES = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        SETTLE = 3'd4,
        FINISH = 3'd5
    } meterState_e;

endpackage

// File: rtl/path_delay_meter_if.sv
// Control/result bundle of the path delay meter; first_fail_idx exists only
// when PATH_METER_FIRST_FAIL_EN is defined.
interface path_delay_meter_if
    import path_meter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             start;
    logic [CNT_W-1:0] trials;
    logic [3:0]       capture_delay;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] fail_count;
    logic [CNT_W-1:0] pass_count;
`ifdef PATH_METER_FIRST_FAIL_EN
    logic [CNT_W-1:0] first_fail_idx;

    modport master (output start, trials, capture_delay,
                    input  busy, done, fail_count, pass_count, first_fail_idx);
    modport slave  (input  start, trials, capture_delay,
                    output busy, done, fail_count, pass_count, first_fail_idx);
`else
    modport master (output start, trials, capture_delay,
                    input  busy, done, fail_count, pass_count);
    modport slave  (input  start, trials, capture_delay,
                    output busy, done, fail_count, pass_count);
`endif

endinterface

// File: rtl/path_capture_ff.sv
// Raw capture flop at the far end of the measured path; kept as its own
// module so placement constraints can pin it next to the path output.
module path_capture_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic capEn,
    input  logic d,
    output logic q
);

    (* keep = "true" *) logic q_r;

    // Samples the path output only on the capture edge, no synchronizer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r <= 1'b0;
        end else if (capEn) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/path_delay_meter.sv
// Launch/capture path delay meter. Optional feature macro:
// PATH_METER_FIRST_FAIL_EN adds first_fail_idx to the control interface.
module path_delay_meter
    import path_meter_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    path_delay_meter_if.slave  ctl,
    output logic               path_launch,
    input  logic               path_result
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]    SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONES    = {CNT_W{1'b1}};

    meterState_e      state_r;
    logic [CNT_W-1:0] trialsLeft_r;
    logic [3:0]       delay_r;
    logic [3:0]       waitCnt_r;
    logic [SW-1:0]    settleCnt_r;
    logic             launch_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] passCnt_r;
    logic [CNT_W-1:0] failCnt_r;
    logic             capEn_s;
    logic             capBit_s;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        if (v == CNT_ONES) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    // Capture fires on the last WAIT cycle, i.e. edge launch+delay+1.
    always_comb begin
        capEn_s = 1'b0;
        if ((state_r == WAIT) && (waitCnt_r == 4'd0)) begin
            capEn_s = 1'b1;
        end else begin
            capEn_s = 1'b0;
        end
    end

    path_capture_ff u_capture (
        .clk   (clk),
        .rst_n (rst_n),
        .capEn (capEn_s),
        .d     (path_result),
        .q     (capBit_s)
    );

    // Measurement sequencer; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            trialsLeft_r <= CNT_ZERO;
            delay_r      <= 4'd0;
            waitCnt_r    <= 4'd0;
            settleCnt_r  <= {SW{1'b0}};
            launch_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            passCnt_r    <= CNT_ZERO;
            failCnt_r    <= CNT_ZERO;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ctl.start) begin
                        trialsLeft_r <= ctl.trials;
                        delay_r      <= ctl.capture_delay;
                        passCnt_r    <= CNT_ZERO;
                        failCnt_r    <= CNT_ZERO;
                        busy_r       <= 1'b1;
                        state_r      <= (ctl.trials == CNT_ZERO) ? FINISH : LAUNCH;
                    end
                end
                LAUNCH: begin
                    // Never re-initialised, so trials alternate rise/fall.
                    launch_r  <= ~launch_r;
                    waitCnt_r <= delay_r;
                    state_r   <= WAIT;
                end
                WAIT: begin
                    if (waitCnt_r == 4'd0) begin
                        state_r <= SAMPLE;
                    end else begin
                        waitCnt_r <= waitCnt_r - 4'd1;
                    end
                end
                SAMPLE: begin
                    if (capBit_s == launch_r) begin
                        passCnt_r <= satInc(passCnt_r);
                    end else begin
                        failCnt_r <= satInc(failCnt_r);
                    end
                    trialsLeft_r <= trialsLeft_r - CNT_ONE;
                    settleCnt_r  <= SETTLE_INIT;
                    state_r      <= SETTLE;
                end
                SETTLE: begin
                    if (settleCnt_r == {SW{1'b0}}) begin
                        state_r <= (trialsLeft_r == CNT_ZERO) ? FINISH : LAUNCH;
                    end else begin
                        settleCnt_r <= settleCnt_r - {{(SW-1){1'b0}}, 1'b1};
                    end
                end
                FINISH: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign path_launch    = launch_r;
    assign ctl.busy       = busy_r;
    assign ctl.done       = done_r;
    assign ctl.pass_count = passCnt_r;
    assign ctl.fail_count = failCnt_r;

`ifdef PATH_METER_FIRST_FAIL_EN
    logic [CNT_W-1:0] trialIdx_r;
    logic [CNT_W-1:0] firstFail_r;

    // Remembers the 0-based index of the first mismatching trial of a run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trialIdx_r  <= CNT_ZERO;
            firstFail_r <= CNT_ONES;
        end else if ((state_r == IDLE) && ctl.start) begin
            trialIdx_r  <= CNT_ZERO;
            firstFail_r <= CNT_ONES;
        end else if (state_r == SAMPLE) begin
            trialIdx_r <= trialIdx_r + CNT_ONE;
            if ((capBit_s != launch_r) && (firstFail_r == CNT_ONES)) begin
                firstFail_r <= trialIdx_r;
            end
        end
    end

    assign ctl.first_fail_idx = firstFail_r;
`endif

endmodule

// File: tb/tb_path_delay_meter.sv
// Directed, table-driven bench for path_delay_meter with a switchable path model.
module tb_path_delay_meter;

    localparam int CNT_W  = 16;
    localparam int SETTLE = 8;
    localparam int NONE   = 65535;

    logic clk = 1'b0;
    logic rst_n;
    logic path_launch;
    logic path_result;

    always #5 clk = ~clk;

    path_delay_meter_if #(.CNT_W(CNT_W)) ifc ();

    path_delay_meter #(.CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctl         (ifc),
        .path_launch (path_launch),
        .path_result (path_result)
    );

    // Path models: 0 = zero delay, 1 = 3-cycle delay, 2 = zero delay with trial 5 inverted.
    int         mode = 0;
    int         togCnt = 0;
    int         togBase = 0;
    logic       lastLaunch = 1'b0;
    logic [2:0] dly = 3'b000;

    always @(posedge clk) dly <= {dly[1:0], path_launch};

    always @(negedge clk) begin
        if (path_launch !== lastLaunch) begin
            togCnt     <= togCnt + 1;
            lastLaunch <= path_launch;
        end
    end

    always_comb begin
        path_result = path_launch;
        case (mode)
            0:       path_result = path_launch;
            1:       path_result = dly[2];
            default: path_result = path_launch ^ ((togCnt - togBase) == 6);
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int  trials;
        int  dly;
        int  mode;
        bit  restart;
        int  expPass;
        int  expFail;
        int  expFirst;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int   n;
        bit   gotDone;
        int   doneSeen;
        logic startLaunch;

        vecs[0] = '{10, 0,  0, 1'b0, 10, 0, NONE};
        vecs[1] = '{4,  1,  1, 1'b0, 0,  4, 0};
        vecs[2] = '{4,  3,  1, 1'b0, 4,  0, NONE};
        vecs[3] = '{0,  5,  0, 1'b0, 0,  0, NONE};
        vecs[4] = '{8,  0,  2, 1'b0, 7,  1, 5};
        vecs[5] = '{3,  2,  1, 1'b1, 0,  3, 0};
        vecs[6] = '{1,  15, 1, 1'b0, 1,  0, NONE};
        vecs[7] = '{5,  0,  0, 1'b1, 5,  0, NONE};

        rst_n             = 1'b0;
        ifc.start         = 1'b0;
        ifc.trials        = 16'd0;
        ifc.capture_delay = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(ifc.busy), 0);
        check("reset_done", int'(ifc.done), 0);
        check("reset_launch", int'(path_launch), 0);
        check("reset_pass", int'(ifc.pass_count), 0);
        check("reset_fail", int'(ifc.fail_count), 0);
`ifdef PATH_METER_FIRST_FAIL_EN
        check("reset_first_fail", int'(ifc.first_fail_idx), NONE);
`endif
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            mode = vecs[i].mode;
            @(negedge clk);
            togBase           = togCnt;
            startLaunch       = path_launch;
            ifc.trials        = 16'(vecs[i].trials);
            ifc.capture_delay = 4'(vecs[i].dly);
            ifc.start         = 1'b1;
            @(posedge clk);
            #1;
            ifc.start = 1'b0;
            check($sformatf("v%0d_busy_after_start", i), int'(ifc.busy), 1);
            n = 0;
            gotDone = 1'b0;
            while (n < 2000 && !gotDone) begin
                @(posedge clk);
                #1;
                n++;
                if (vecs[i].restart && n == 5) begin
                    ifc.start  = 1'b1;
                    ifc.trials = 16'd7;
                end else begin
                    ifc.start = 1'b0;
                end
                if (ifc.done) gotDone = 1'b1;
            end
            check($sformatf("v%0d_done_seen", i), int'(gotDone), 1);
            check($sformatf("v%0d_latency", i), n, vecs[i].trials * (vecs[i].dly + 3 + SETTLE) + 1);
            check($sformatf("v%0d_pass", i), int'(ifc.pass_count), vecs[i].expPass);
            check($sformatf("v%0d_fail", i), int'(ifc.fail_count), vecs[i].expFail);
            check($sformatf("v%0d_busy_at_done", i), int'(ifc.busy), 0);
            check($sformatf("v%0d_toggles", i), togCnt - togBase, vecs[i].trials);
            check($sformatf("v%0d_launch_level", i), int'(path_launch),
                  int'(startLaunch ^ vecs[i].trials[0]));
`ifdef PATH_METER_FIRST_FAIL_EN
            check($sformatf("v%0d_first_fail", i), int'(ifc.first_fail_idx), vecs[i].expFirst);
`endif
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_one_cycle", i), int'(ifc.done), 0);
        end

        // start during FINISH is dropped, start in the following IDLE cycle is taken
        mode = 0;
        @(negedge clk);
        ifc.trials        = 16'd1;
        ifc.capture_delay = 4'd0;
        ifc.start         = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        check("finish_done", int'(ifc.done), 1);
        check("finish_start_ignored", int'(ifc.busy), 0);
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        check("idle_start_accepted", int'(ifc.busy), 1);
        check("idle_start_clears_pass", int'(ifc.pass_count), 0);
        n = 0;
        gotDone = 1'b0;
        while (n < 100 && !gotDone) begin
            @(posedge clk);
            #1;
            n++;
            if (ifc.done) gotDone = 1'b1;
        end
        check("rerun_done_seen", int'(gotDone), 1);
        repeat (5) @(posedge clk);
        #1;
        check("counters_hold_pass", int'(ifc.pass_count), 1);
        check("counters_hold_fail", int'(ifc.fail_count), 0);

        // reset during WAIT of trial 2 aborts without a done pulse
        mode = 1;
        @(negedge clk);
        togBase           = togCnt;
        ifc.trials        = 16'd4;
        ifc.capture_delay = 4'd3;
        ifc.start         = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        n = 0;
        while (n < 200 && (togCnt - togBase) < 2) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reached_trial2", togCnt - togBase, 2);
        check("pre_reset_pass", int'(ifc.pass_count), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrun_reset_busy", int'(ifc.busy), 0);
        check("midrun_reset_done", int'(ifc.done), 0);
        check("midrun_reset_launch", int'(path_launch), 0);
        check("midrun_reset_pass", int'(ifc.pass_count), 0);
        check("midrun_reset_fail", int'(ifc.fail_count), 0);
        rst_n = 1'b1;
        doneSeen = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (ifc.done || ifc.busy) doneSeen++;
        end
        check("midrun_reset_no_done", doneSeen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
